// File: rtl/sram_pkg.sv
// Shared types and widths for the SRAM port arbiter and its read-tag pipeline.
package sram_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_TURN  = 2'd3
  } bus_state_e;

  typedef enum logic [1:0] {
    OWN_DISP = 2'd0,
    OWN_CAP  = 2'd1,
    OWN_ENG  = 2'd2
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side handshake bundle: display reader, capture writer and rendering engine.
interface sram_port_arbiter_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) ();

  logic              i_disp_req;
  logic [ADDR_W-1:0] i_disp_addr;
  logic              o_disp_gnt;
  logic [DATA_W-1:0] o_disp_rdata;
  logic              o_disp_rvalid;

  logic              i_cap_req;
  logic [ADDR_W-1:0] i_cap_addr;
  logic [DATA_W-1:0] i_cap_wdata;
  logic              o_cap_gnt;

  logic              i_eng_req;
  logic              i_eng_we;
  logic [ADDR_W-1:0] i_eng_addr;
  logic [DATA_W-1:0] i_eng_wdata;
  logic              o_eng_gnt;
  logic [DATA_W-1:0] o_eng_rdata;
  logic              o_eng_rvalid;

  modport master (
    output i_disp_req, i_disp_addr,
    input  o_disp_gnt, o_disp_rdata, o_disp_rvalid,
    output i_cap_req, i_cap_addr, i_cap_wdata,
    input  o_cap_gnt,
    output i_eng_req, i_eng_we, i_eng_addr, i_eng_wdata,
    input  o_eng_gnt, o_eng_rdata, o_eng_rvalid
  );

  modport slave (
    input  i_disp_req, i_disp_addr,
    output o_disp_gnt, o_disp_rdata, o_disp_rvalid,
    input  i_cap_req, i_cap_addr, i_cap_wdata,
    output o_cap_gnt,
    input  i_eng_req, i_eng_we, i_eng_addr, i_eng_wdata,
    output o_eng_gnt, o_eng_rdata, o_eng_rvalid
  );

endinterface

// File: rtl/sram_rd_tag_pipe.sv
// Two-stage {valid, owner} tag shift that follows each SRAM read and steers the
// sampled bus data to the requester that issued it.
module sram_rd_tag_pipe
  import sram_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              rd_issue,
  input  owner_e            rd_owner,
  input  logic [DATA_W-1:0] bus_dq,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] eng_rdata,
  output logic              eng_rvalid
);

  rd_tag_t           tag0_r;
  rd_tag_t           tag1_r;
  logic [DATA_W-1:0] disp_rdata_r;
  logic [DATA_W-1:0] eng_rdata_r;

  // Stage 0 is live while the SRAM drives the bus; its data is captured for the owner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag0_r       <= rd_tag_t'{valid: 1'b0, owner: OWN_DISP};
      tag1_r       <= rd_tag_t'{valid: 1'b0, owner: OWN_DISP};
      disp_rdata_r <= {DATA_W{1'b0}};
      eng_rdata_r  <= {DATA_W{1'b0}};
    end else begin
      tag0_r <= rd_tag_t'{valid: rd_issue, owner: rd_owner};
      tag1_r <= tag0_r;
      if (tag0_r.valid && (tag0_r.owner == OWN_DISP)) begin
        disp_rdata_r <= bus_dq;
      end
      if (tag0_r.valid && (tag0_r.owner == OWN_ENG)) begin
        eng_rdata_r <= bus_dq;
      end
    end
  end

  assign disp_rdata  = disp_rdata_r;
  assign eng_rdata   = eng_rdata_r;
  assign disp_rvalid = tag1_r.valid && (tag1_r.owner == OWN_DISP);
  assign eng_rvalid  = tag1_r.valid && (tag1_r.owner == OWN_ENG);

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: display > capture > engine with engine anti-starvation,
// read-to-write turnaround on the shared data bus, and CCD pause on held-off capture.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_port_arbiter_if.slave bus,
  output logic [ADDR_W-1:0] o_s_addr,
  output logic              o_s_wen,
  inout  wire  [DATA_W-1:0] io_s_dq,
  output logic              o_CCD_pause
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  bus_state_e        state_r;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [ADDR_W-1:0] s_addr_r;
  logic [DATA_W-1:0] s_wdata_r;
  logic              s_wen_r;
  logic              pause_r;

  logic   disp_gnt_s, cap_gnt_s, eng_gnt_s;
  logic   in_read_s, cap_ok_s, eng_ok_s, starved_s, write_pend_s;
  logic   rd_issue_s, wr_issue_s;
  owner_e rd_owner_s;

  // Grant selection; writes sit out a cycle after a read so the bus can turn around.
  always_comb begin
    disp_gnt_s   = 1'b0;
    cap_gnt_s    = 1'b0;
    eng_gnt_s    = 1'b0;
    in_read_s    = (state_r == S_READ);
    starved_s    = (starve_cnt_r == CNT_W'(STARVE_MAX));
    cap_ok_s     = bus.i_cap_req && !in_read_s;
    eng_ok_s     = bus.i_eng_req && !(bus.i_eng_we && in_read_s);
    write_pend_s = bus.i_cap_req || (bus.i_eng_req && bus.i_eng_we);
    if (bus.i_disp_req) begin
      disp_gnt_s = 1'b1;
    end else if (starved_s && eng_ok_s) begin
      eng_gnt_s = 1'b1;
    end else if (cap_ok_s) begin
      cap_gnt_s = 1'b1;
    end else if (eng_ok_s) begin
      eng_gnt_s = 1'b1;
    end else begin
      disp_gnt_s = 1'b0;
    end
    rd_issue_s = disp_gnt_s || (eng_gnt_s && !bus.i_eng_we);
    wr_issue_s = cap_gnt_s || (eng_gnt_s && bus.i_eng_we);
    rd_owner_s = disp_gnt_s ? OWN_DISP : OWN_ENG;
  end

  // Engine starvation counter, saturating at the promotion threshold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end else if (bus.i_eng_req && !eng_gnt_s) begin
      if (!starved_s) begin
        starve_cnt_r <= starve_cnt_r + CNT_W'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {CNT_W{1'b0}};
    end
  end

  // Bus FSM and SRAM pin registers; state names the access on the pins this cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= S_IDLE;
      s_addr_r  <= {ADDR_W{1'b0}};
      s_wdata_r <= {DATA_W{1'b0}};
      s_wen_r   <= 1'b1;
      pause_r   <= 1'b0;
    end else begin
      pause_r <= bus.i_cap_req && !cap_gnt_s;
      if (rd_issue_s) begin
        state_r  <= S_READ;
        s_wen_r  <= 1'b1;
        s_addr_r <= disp_gnt_s ? bus.i_disp_addr : bus.i_eng_addr;
      end else if (wr_issue_s) begin
        state_r   <= S_WRITE;
        s_wen_r   <= 1'b0;
        s_addr_r  <= cap_gnt_s ? bus.i_cap_addr : bus.i_eng_addr;
        s_wdata_r <= cap_gnt_s ? bus.i_cap_wdata : bus.i_eng_wdata;
      end else begin
        s_wen_r <= 1'b1;
        state_r <= (in_read_s && write_pend_s) ? S_TURN : S_IDLE;
      end
    end
  end

  assign bus.o_disp_gnt = disp_gnt_s;
  assign bus.o_cap_gnt  = cap_gnt_s;
  assign bus.o_eng_gnt  = eng_gnt_s;
  assign o_s_addr       = s_addr_r;
  assign o_s_wen        = s_wen_r;
  assign o_CCD_pause    = pause_r;
  assign io_s_dq        = s_wen_r ? {DATA_W{1'bz}} : s_wdata_r;

  sram_rd_tag_pipe #(.DATA_W(DATA_W)) u_rd_tag_pipe (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .rd_issue    (rd_issue_s),
    .rd_owner    (rd_owner_s),
    .bus_dq      (io_s_dq),
    .disp_rdata  (bus.o_disp_rdata),
    .disp_rvalid (bus.o_disp_rvalid),
    .eng_rdata   (bus.o_eng_rdata),
    .eng_rvalid  (bus.o_eng_rvalid)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM model and a read-return scoreboard.
module tb_sram_port_arbiter;
  import sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();
  logic [19:0] s_addr;
  logic        s_wen;
  wire  [15:0] s_dq;
  logic        pause;

  sram_port_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_s_addr    (s_addr),
    .o_s_wen     (s_wen),
    .io_s_dq     (s_dq),
    .o_CCD_pause (pause)
  );

  // SRAM model: drives the bus whenever the arbiter is not writing.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) begin
        if (i >= 16 && i < 20) mem[i] <= 16'h1234 + 16'(i - 16);
        else                   mem[i] <= 16'hC000 | 16'(i);
      end
    end else if (!s_wen) begin
      mem[s_addr[9:0]] <= s_dq;
    end
  end
  assign s_dq = s_wen ? mem[s_addr[9:0]] : 16'hzzzz;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        is_eng;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic expect_rd(input logic is_eng, input logic [15:0] d);
    exp_q.push_back(exp_t'{is_eng: is_eng, data: d});
  endtask

  // Monitor: every read return is matched against the oldest expected read.
  always @(negedge clk) begin
    if (bus.o_disp_rvalid || bus.o_eng_rvalid) begin
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'({bus.o_disp_rvalid, bus.o_eng_rvalid}), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_owner", 32'({bus.o_disp_rvalid, bus.o_eng_rvalid}),
            mon_e.is_eng ? 32'd1 : 32'd2);
        chk("rd_data", 32'(bus.o_disp_rvalid ? bus.o_disp_rdata : bus.o_eng_rdata),
            32'(mon_e.data));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    bus.i_disp_req  = 1'b0;
    bus.i_disp_addr = 20'h0;
    bus.i_cap_req   = 1'b0;
    bus.i_cap_addr  = 20'h0;
    bus.i_cap_wdata = 16'h0;
    bus.i_eng_req   = 1'b0;
    bus.i_eng_we    = 1'b0;
    bus.i_eng_addr  = 20'h0;
    bus.i_eng_wdata = 16'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic exp_eng;
    idle_inputs();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_wen", 32'(s_wen), 32'd1);
    chk("rst_addr", 32'(s_addr), 32'd0);
    chk("rst_pause", 32'(pause), 32'd0);
    chk("rst_rvalid", 32'({bus.o_disp_rvalid, bus.o_eng_rvalid}), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Display alone, back-to-back reads.
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.i_disp_req  = 1'b1;
      bus.i_disp_addr = 20'h10 + 20'(k);
      settle();
      chk("a_disp_gnt", 32'(bus.o_disp_gnt), 32'd1);
      expect_rd(1'b0, 16'h1234 + 16'(k));
      if (k > 0) begin
        chk("a_addr", 32'(s_addr), 32'h10 + 32'(k - 1));
        chk("a_wen", 32'(s_wen), 32'd1);
      end
    end
    cyc();
    bus.i_disp_req = 1'b0;
    settle();
    chk("a_gnt_idle", 32'(bus.o_disp_gnt), 32'd0);
    chk("a_last_addr", 32'(s_addr), 32'h13);

    // Capture write then display read of the same word: no turnaround needed.
    cyc();
    bus.i_cap_req   = 1'b1;
    bus.i_cap_addr  = 20'h5;
    bus.i_cap_wdata = 16'hABCD;
    settle();
    chk("b_cap_gnt", 32'(bus.o_cap_gnt), 32'd1);
    cyc();
    bus.i_cap_req   = 1'b0;
    bus.i_disp_req  = 1'b1;
    bus.i_disp_addr = 20'h5;
    settle();
    chk("b_disp_gnt", 32'(bus.o_disp_gnt), 32'd1);
    chk("b_wen", 32'(s_wen), 32'd0);
    chk("b_dq", 32'(s_dq), 32'h0000ABCD);
    chk("b_addr", 32'(s_addr), 32'h5);
    chk("b_pause", 32'(pause), 32'd0);
    expect_rd(1'b0, 16'hABCD);
    cyc();
    bus.i_disp_req = 1'b0;
    settle();
    chk("b_rd_wen", 32'(s_wen), 32'd1);

    // Read followed by capture write: one dead turnaround cycle.
    cyc();
    bus.i_disp_req  = 1'b1;
    bus.i_disp_addr = 20'h20;
    settle();
    chk("c_disp_gnt", 32'(bus.o_disp_gnt), 32'd1);
    expect_rd(1'b0, 16'hC020);
    cyc();
    bus.i_disp_req  = 1'b0;
    bus.i_cap_req   = 1'b1;
    bus.i_cap_addr  = 20'h30;
    bus.i_cap_wdata = 16'h5A5A;
    settle();
    chk("c_cap_denied", 32'(bus.o_cap_gnt), 32'd0);
    cyc();
    settle();
    chk("c_cap_gnt", 32'(bus.o_cap_gnt), 32'd1);
    chk("c_turn_wen", 32'(s_wen), 32'd1);
    chk("c_pause_set", 32'(pause), 32'd1);
    cyc();
    bus.i_cap_req = 1'b0;
    settle();
    chk("c_wr_wen", 32'(s_wen), 32'd0);
    chk("c_wr_dq", 32'(s_dq), 32'h00005A5A);
    chk("c_pause_clr", 32'(pause), 32'd0);

    // Capture and engine contend continuously: engine promoted after 8 denials.
    for (int k = 0; k < 18; k++) begin
      cyc();
      if (k == 0) begin
        bus.i_cap_req   = 1'b1;
        bus.i_cap_addr  = 20'h40;
        bus.i_cap_wdata = 16'h1111;
        bus.i_eng_req   = 1'b1;
        bus.i_eng_we    = 1'b1;
        bus.i_eng_addr  = 20'h50;
        bus.i_eng_wdata = 16'h2222;
      end
      settle();
      exp_eng = (k == 8) || (k == 17);
      chk("d_eng_gnt", 32'(bus.o_eng_gnt), 32'(exp_eng));
      chk("d_cap_gnt", 32'(bus.o_cap_gnt), 32'(!exp_eng));
      if (k == 9)  chk("d_pause_set", 32'(pause), 32'd1);
      if (k == 10) chk("d_pause_clr", 32'(pause), 32'd0);
    end
    cyc();
    idle_inputs();

    // Engine read with reset asserted one cycle later: no return after release.
    cyc();
    bus.i_eng_req  = 1'b1;
    bus.i_eng_we   = 1'b0;
    bus.i_eng_addr = 20'h60;
    settle();
    chk("e_eng_gnt", 32'(bus.o_eng_gnt), 32'd1);
    cyc();
    bus.i_eng_req = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("e_rst_addr", 32'(s_addr), 32'd0);
    chk("e_rst_wen", 32'(s_wen), 32'd1);
    chk("e_rst_pause", 32'(pause), 32'd0);
    chk("e_rst_disp_rdata", 32'(bus.o_disp_rdata), 32'd0);
    chk("e_rst_eng_rvalid", 32'(bus.o_eng_rvalid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      settle();
      chk("e_no_rvalid", 32'(bus.o_eng_rvalid), 32'd0);
    end

    // Display and engine reads alternate every cycle.
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k % 2 == 0) begin
        bus.i_eng_req   = 1'b0;
        bus.i_disp_req  = 1'b1;
        bus.i_disp_addr = 20'h70 + 20'(k);
      end else begin
        bus.i_disp_req = 1'b0;
        bus.i_eng_req  = 1'b1;
        bus.i_eng_we   = 1'b0;
        bus.i_eng_addr = 20'h70 + 20'(k);
      end
      settle();
      if (k % 2 == 0) chk("f_disp_gnt", 32'(bus.o_disp_gnt), 32'd1);
      else            chk("f_eng_gnt", 32'(bus.o_eng_gnt), 32'd1);
      expect_rd(k % 2 == 1, 16'hC070 + 16'(k));
    end
    cyc();
    idle_inputs();
    repeat (4) cyc();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
